// File: rtl/sm_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sm_arb_pkg
//  Purpose : Shared encodings and widths for the state-machine request
//            arbiter (FSM state codes, id and counter widths).
//  Ports   : none (package)
//  Revision: 1.0  initial release
// ============================================================================
package sm_arb_pkg;

   localparam int ID_W  = 3;
   localparam int CNT_W = 4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_APPLY   = 2'd1;
   localparam logic [1:0] ST_SAMPLE  = 2'd2;
   localparam logic [1:0] ST_RELEASE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_APPLY   = ST_APPLY,
      S_SAMPLE  = ST_SAMPLE,
      S_RELEASE = ST_RELEASE
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Purpose : Combinational round-robin picker. Returns the first asserted
//            request at or after rr_ptr, searching upward and wrapping at
//            NUM_REQ.
//  Ports   : req     in  NUM_REQ  request vector
//            rr_ptr  in  ID_W     search start index (always < NUM_REQ)
//            any     out 1        at least one request present
//            id      out ID_W     index of the selected requester
//  Revision: 1.0  initial release
// ============================================================================
module rr_pick
   import sm_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               any,
   output logic [ID_W-1:0]    id
);

   // Padded to 16 bits so a 4-bit index addresses it exactly.
   logic [15:0] req_pad;
   logic [3:0]  idx;

   // Walk offsets from the farthest to the nearest; the last hit wins, so
   // the smallest offset from rr_ptr is the one that ends up in id.
   always_comb begin
      req_pad = 16'(req);
      any     = |req;
      id      = '0;
      idx     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, rr_ptr} + 4'(k);
         if (idx >= 4'(NUM_REQ)) begin
            idx = idx - 4'(NUM_REQ);
         end
         if (req_pad[idx]) begin
            id = idx[ID_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sm_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : sm_request_arbiter
//  Purpose : Shares one 3-in/2-out control state machine between NUM_REQ
//            requesters, round-robin. The winner's vector is held on x1..x3
//            for HOLD_CYCLES, then {z2,z1} is sampled and returned.
//  Ports   : clk      in  1            system clock, rising edge
//            rst_n    in  1            asynchronous active-low reset
//            req      in  NUM_REQ      level request per requester
//            req_x    in  3*NUM_REQ    vector per requester {x3,x2,x1}
//            gnt      out NUM_REQ      one-hot grant, registered
//            done     out 1            one-cycle pulse, response valid
//            resp_id  out 3            requester being answered
//            resp_z   out 2            sampled {z2,z1}
//            x1..x3   out 1 each       drive to the state machine
//            z1,z2    in  1 each       from the state machine
//  Revision: 1.0  initial release
// ============================================================================
module sm_request_arbiter
   import sm_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [3*NUM_REQ-1:0]   req_x,
   output logic [NUM_REQ-1:0]     gnt,
   output logic                   done,
   output logic [ID_W-1:0]        resp_id,
   output logic [1:0]             resp_z,
   output logic                   x1,
   output logic                   x2,
   output logic                   x3,
   input  logic                   z1,
   input  logic                   z2
);

   state_t              state, next_state;
   logic [ID_W-1:0]     cur_id, next_id;
   logic [ID_W-1:0]     rr_ptr, next_rr_ptr;
   logic [CNT_W-1:0]    cnt, next_cnt;
   logic [2:0]          x_vec, next_x;
   logic [NUM_REQ-1:0]  next_gnt;
   logic                next_done;
   logic [ID_W-1:0]     next_resp_id;
   logic [1:0]          next_resp_z;

   logic                pick_any;
   logic [ID_W-1:0]     pick_id;
   logic [2:0]          pick_x;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req    (req),
      .rr_ptr (rr_ptr),
      .any    (pick_any),
      .id     (pick_id)
   );

   // Vector of the requester the picker selected this cycle.
   always_comb begin
      pick_x = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_id == ID_W'(i)) begin
            pick_x = req_x[3*i +: 3];
         end
      end
   end

   assign {x3, x2, x1} = x_vec;

   // Next-state and next-output logic.
   always_comb begin
      next_state   = state;
      next_id      = cur_id;
      next_rr_ptr  = rr_ptr;
      next_cnt     = cnt;
      next_x       = x_vec;
      next_gnt     = gnt;
      next_done    = 1'b0;
      next_resp_id = resp_id;
      next_resp_z  = resp_z;

      case (state)
         S_IDLE: begin
            if (pick_any) begin
               next_id    = pick_id;
               next_x     = pick_x;
               next_gnt   = NUM_REQ'(1) << pick_id;
               next_cnt   = CNT_W'(HOLD_CYCLES - 1);
               next_state = S_APPLY;
            end
         end
         S_APPLY: begin
            if (cnt == '0) begin
               next_state = S_SAMPLE;
            end else begin
               next_cnt = cnt - CNT_W'(1);
            end
         end
         S_SAMPLE: begin
            next_resp_z  = {z2, z1};
            next_resp_id = cur_id;
            next_done    = 1'b1;
            // Modulo NUM_REQ wrap, which need not be a power of two.
            next_rr_ptr  = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + ID_W'(1);
            next_state   = S_RELEASE;
         end
         S_RELEASE: begin
            next_gnt   = '0;
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cur_id  <= '0;
         rr_ptr  <= '0;
         cnt     <= '0;
         x_vec   <= '0;
         gnt     <= '0;
         done    <= 1'b0;
         resp_id <= '0;
         resp_z  <= '0;
      end else begin
         state   <= next_state;
         cur_id  <= next_id;
         rr_ptr  <= next_rr_ptr;
         cnt     <= next_cnt;
         x_vec   <= next_x;
         gnt     <= next_gnt;
         done    <= next_done;
         resp_id <= next_resp_id;
         resp_z  <= next_resp_z;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sm_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sm_request_arbiter
//  Purpose : Self-checking bench for sm_request_arbiter (NUM_REQ=4,
//            HOLD_CYCLES=2) with a behavioural model of the shared state
//            machine and a queue of expected responses.
//  Ports   : none
//  Revision: 1.0  initial release
// ============================================================================
module tb_sm_request_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int HOLD_CYCLES = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req;
   logic [3*NUM_REQ-1:0] req_x;
   logic [NUM_REQ-1:0]   gnt;
   logic                 done;
   logic [2:0]           resp_id;
   logic [1:0]           resp_z;
   logic                 x1, x2, x3;
   logic                 z1, z2;

   typedef struct packed {
      logic [2:0] id;
      logic [1:0] z;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   // Behavioural model of the shared state machine's outputs, v = {x3,x2,x1}.
   function automatic logic [1:0] model_z(input logic [2:0] v);
      logic zz1, zz2;
      zz1 = v[0] ^ v[1] ^ v[2];
      zz2 = v[2] ^ (v[1] & v[0]);
      return {zz2, zz1};
   endfunction

   assign {z2, z1} = model_z({x3, x2, x1});

   sm_request_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .req_x   (req_x),
      .gnt     (gnt),
      .done    (done),
      .resp_id (resp_id),
      .resp_z  (resp_z),
      .x1      (x1),
      .x2      (x2),
      .x3      (x3),
      .z1      (z1),
      .z2      (z2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push(input int id, input logic [2:0] v);
      exp_t e;
      e.id = 3'(id);
      e.z  = model_z(v);
      exp_q.push_back(e);
   endtask

   // Waits for the first nonzero grant; returns the cycle it was seen.
   task automatic wait_gnt(input string tag, input logic [NUM_REQ-1:0] expg, output int at);
      int n = 0;
      at = -1;
      while (n < 8) begin
         @(negedge clk);
         n++;
         if (gnt !== '0) begin
            at = cyc;
            break;
         end
      end
      chk({tag, "_gnt"}, 32'(gnt), 32'(expg));
   endtask

   // Waits for done; pops the scoreboard and compares the response.
   task automatic wait_done(input string tag, output int at);
      int   n = 0;
      exp_t e;
      at = -1;
      while (n < 12) begin
         @(negedge clk);
         n++;
         chk({tag, "_gnt_onehot0"}, 32'($onehot0(gnt)), 32'd1);
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         chk({tag, "_done_timeout"}, 32'(done), 32'd1);
      end else if (exp_q.size() == 0) begin
         chk({tag, "_unexpected_done"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_resp_id"}, 32'(resp_id), 32'(e.id));
         chk({tag, "_resp_z"},  32'(resp_z),  32'(e.z));
      end
   endtask

   task automatic pulse_end(input string tag);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int g, d, prev, r;

      // Reset held with all requests high.
      rst_n = 1'b0;
      req   = 4'b1111;
      req_x = {3'b100, 3'b110, 3'b011, 3'b001};
      repeat (3) begin
         @(negedge clk);
         chk("rst_gnt",  32'(gnt), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_x",    32'({x3, x2, x1}), 32'd0);
      end
      rst_n = 1'b1;
      r = cyc;
      push(0, req_x[2:0]);
      push(1, req_x[5:3]);
      push(2, req_x[8:6]);
      push(3, req_x[11:9]);
      push(0, req_x[2:0]);
      wait_gnt("rst_first", 4'b0001, g);
      chk("rst_first_latency", 32'(g - r), 32'd1);
      chk("rst_first_x", 32'({x3, x2, x1}), 32'(req_x[2:0]));

      // Round-robin with all requests held.
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         wait_done("rr", d);
         if (k == 0) chk("rr_first_done_latency", 32'(d - g), 32'(HOLD_CYCLES + 1));
         else        chk("rr_done_period", 32'(d - prev), 32'(HOLD_CYCLES + 3));
         prev = d;
      end
      req = 4'b0000;
      pulse_end("rr");
      chk("rr_release_gnt", 32'(gnt), 32'd0);

      // Single request; rr_ptr is 1 here.
      req_x[8:6] = 3'b011;
      req        = 4'b0100;
      r          = cyc;
      push(2, 3'b011);
      wait_gnt("single", 4'b0100, g);
      chk("single_latency", 32'(g - r), 32'd1);
      chk("single_x", 32'({x3, x2, x1}), 32'b011);
      wait_done("single", d);
      chk("single_done_latency", 32'(d - g), 32'(HOLD_CYCLES + 1));
      req = 4'b0000;
      pulse_end("single");

      // Wrap with gaps: rr_ptr is 3, requesters 0 and 1 asking.
      req = 4'b0011;
      push(0, req_x[2:0]);
      push(1, req_x[5:3]);
      wait_gnt("wrap_a", 4'b0001, g);
      wait_done("wrap_a", d);
      pulse_end("wrap_a");
      wait_gnt("wrap_b", 4'b0010, g);
      chk("wrap_b_x", 32'({x3, x2, x1}), 32'(req_x[5:3]));
      wait_done("wrap_b", d);
      req = 4'b0000;
      pulse_end("wrap_b");

      // Mid-transaction drop of req and change of req_x; rr_ptr is 2.
      req_x[5:3] = 3'b101;
      req        = 4'b0010;
      push(1, 3'b101);
      wait_gnt("mid", 4'b0010, g);
      chk("mid_x_apply", 32'({x3, x2, x1}), 32'b101);
      req        = 4'b0000;
      req_x[5:3] = 3'b010;
      @(negedge clk);
      chk("mid_x_held", 32'({x3, x2, x1}), 32'b101);
      chk("mid_gnt_held", 32'(gnt), 32'b0010);
      wait_done("mid", d);
      pulse_end("mid");
      repeat (2) begin
         @(negedge clk);
         chk("idle_x_kept", 32'({x3, x2, x1}), 32'b101);
         chk("idle_gnt", 32'(gnt), 32'd0);
      end

      // Reset in the middle of a transaction; rr_ptr is 2, so 3 wins.
      req = 4'b1000;
      wait_gnt("abort", 4'b1000, g);
      chk("abort_x", 32'({x3, x2, x1}), 32'(req_x[11:9]));
      rst_n = 1'b0;
      req   = 4'b1111;
      #1;
      chk("abort_gnt", 32'(gnt), 32'd0);
      chk("abort_x0",  32'({x3, x2, x1}), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      push(0, req_x[2:0]);
      wait_gnt("resume", 4'b0001, g);
      wait_done("resume", d);
      req = 4'b0000;
      pulse_end("resume");
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
